// File: rtl/mem_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | rv32i_mem_pkg : shared types and constants for the rv32i memory system   |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } mem_owner_t;

  localparam int unsigned MEM_AW_DEFAULT = 15;
  localparam logic [31:0] MMIO_OUT_ADDR  = 32'h1000_0000;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter_if : fetch, load/store and memory-port signals of the arbiter |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) ();

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_we;
  logic              data_gnt;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;

  // Requesters and RAM side: drive requests and read data, observe the rest.
  modport master (
    output inst_req, inst_addr,
    output data_req, data_addr, data_wdata, data_we,
    output mem_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_we
  );

  // Arbiter side.
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_addr, data_wdata, data_we,
    input  mem_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_en, mem_addr, mem_wdata, mem_we
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// +--------------------------------------------------------------------------+
// | mem_arb_pick : two-input grant selector (bit 0 = inst, bit 1 = data)     |
// | Build macro  : MEM_ARB_RR_EN selects round-robin, else data-over-inst    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arb_pick
  import rv32i_mem_pkg::*;
(
  input  wire logic [1:0] req_i,
  input  mem_owner_t      last_i,
  output logic [1:0]      gnt_o
);

`ifdef MEM_ARB_RR_EN
  // On a conflict the side that did not win most recently goes first.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == OWN_DATA) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_o = req_i;
    if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter : shares one 1-cycle-latency word RAM between fetch and LSU  |
// | Build macro : MEM_ARB_RR_EN (round-robin conflict policy, in the picker) |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
  input wire logic     clk,
  input wire logic     reset,
  mem_arbiter_if.slave bus
);

  logic [1:0] req_w;
  logic [1:0] gnt_w;
  mem_owner_t owner_d, owner_q;
  mem_owner_t last_d, last_q;

  // Reset masks requests so nothing is granted or written while it is held.
  assign req_w = {bus.data_req, bus.inst_req} & {2{~reset}};

  mem_arb_pick u_pick (
    .req_i  (req_w),
    .last_i (last_q),
    .gnt_o  (gnt_w)
  );

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_w[1]) begin
      owner_d = OWN_DATA;
    end else if (gnt_w[0]) begin
      owner_d = OWN_INST;
    end
    last_d = (owner_d == OWN_NONE) ? last_q : owner_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= OWN_INST;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.inst_gnt  = gnt_w[0];
  assign bus.data_gnt  = gnt_w[1];
  assign bus.mem_en    = |gnt_w;
  assign bus.mem_addr  = gnt_w[1] ? bus.data_addr[MEM_AW+1:2] : bus.inst_addr[MEM_AW+1:2];
  assign bus.mem_wdata = bus.data_wdata;
  assign bus.mem_we    = gnt_w[1] ? bus.data_we : 4'b0000;

  // A response in flight when reset arrives is dropped here, not in the RAM.
  assign bus.inst_rvalid = (owner_q == OWN_INST) & ~reset;
  assign bus.data_rvalid = (owner_q == OWN_DATA) & ~reset;
  assign bus.inst_rdata  = bus.mem_rdata;
  assign bus.data_rdata  = bus.mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_addr[ADDR_W-1:MEM_AW+2], bus.inst_addr[1:0],
                              bus.data_addr[ADDR_W-1:MEM_AW+2], bus.data_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : vector-table bench for mem_arbiter with a RAM model     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        igt;
    logic        dgt;
    logic        men;
    logic [14:0] maddr;
    logic [3:0]  mwe;
    logic        irv;
    logic        drv;
    logic        cird;
    logic [31:0] ird;
    logic        cdrd;
    logic [31:0] drd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  vec_t vq[$];

  mem_arbiter_if #(.ADDR_W(32), .MEM_AW(15)) bus ();

  mem_arbiter #(.ADDR_W(32), .MEM_AW(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: word i holds 0x5A00_0000|i, except word 4 holds 0x13.
  logic [31:0] mem [0:32767];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] = 32'h5A00_0000 | i;
      mem[4] = 32'h0000_0013;
      mem_ready = 1'b1;
    end
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic [31:0] daddr, input logic [31:0] wdata,
                     input logic [3:0] we, input logic igt, input logic dgt, input logic men,
                     input logic [14:0] maddr, input logic [3:0] mwe, input logic irv,
                     input logic drv, input logic cird, input logic [31:0] ird,
                     input logic cdrd, input logic [31:0] drd);
    vec_t v;
    v = '{rst, ireq, iaddr, dreq, daddr, wdata, we, igt, dgt, men, maddr, mwe,
          irv, drv, cird, ird, cdrd, drd};
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic [31:0] daddr,
                       input logic [31:0] wdata, input logic [3:0] we);
    reset          = rst;
    bus.inst_req   = ireq;
    bus.inst_addr  = iaddr;
    bus.data_req   = dreq;
    bus.data_addr  = daddr;
    bus.data_wdata = wdata;
    bus.data_we    = we;
  endtask

  initial begin
    logic [1:0] exp_g;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

    //  rst ireq iaddr        dreq daddr         wdata          we     igt dgt men maddr  mwe    irv drv cird ird            cdrd drd
    add(1, 1, 32'h10,       1, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(1, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 1, 32'h10,       0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd4, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  1, 0, 1, 32'h0000_0013,  0, 32'h0);
    add(0, 1, 32'h20,       1, 32'h1000_0000, 32'h41,       4'h1,  0, 1, 1, 15'd0, 4'h1,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 1, 32'h20,       0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd8, 4'h0,  0, 1, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        1, 32'h100,      32'hDEAD_BEEF, 4'hF,  0, 1, 1, 15'h40, 4'hF, 1, 0, 1, 32'h5A00_0008,  0, 32'h0);
    add(0, 0, 32'h0,        1, 32'h100,      32'h0,         4'h0,  0, 1, 1, 15'h40, 4'h0, 0, 1, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 1, 0, 32'h0,          1, 32'hDEAD_BEEF);
    add(0, 0, 32'h0,        1, 32'h0,        32'h0,         4'h0,  0, 1, 1, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 1, 0, 32'h0,          1, 32'h5A00_0041);
    add(0, 1, 32'h0,        0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 1, 32'h4,        0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd1, 4'h0,  1, 0, 1, 32'h5A00_0041,  0, 32'h0);
    add(0, 1, 32'h8,        0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd2, 4'h0,  1, 0, 1, 32'h5A00_0001,  0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  1, 0, 1, 32'h5A00_0002,  0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 1, 32'h13,       0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd4, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(1, 1, 32'h10,       0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(1, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 1, 32'h10,       0, 32'h0,        32'h0,         4'h0,  1, 0, 1, 15'd4, 4'h0,  0, 0, 0, 32'h0,          0, 32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 15'd0, 4'h0,  1, 0, 1, 32'h0000_0013,  0, 32'h0);

    foreach (vq[n]) begin
      @(negedge clk);
      drive(vq[n].rst, vq[n].ireq, vq[n].iaddr, vq[n].dreq, vq[n].daddr, vq[n].wdata, vq[n].we);
      #4;
      check($sformatf("v%0d ctrl{igt,dgt,en,we,irv,drv}", n),
            {23'd0, bus.inst_gnt, bus.data_gnt, bus.mem_en, bus.mem_we, bus.inst_rvalid, bus.data_rvalid},
            {23'd0, vq[n].igt, vq[n].dgt, vq[n].men, vq[n].mwe, vq[n].irv, vq[n].drv});
      if (vq[n].men)  check($sformatf("v%0d mem_addr", n), {17'd0, bus.mem_addr}, {17'd0, vq[n].maddr});
      if (vq[n].cird) check($sformatf("v%0d inst_rdata", n), bus.inst_rdata, vq[n].ird);
      if (vq[n].cdrd) check($sformatf("v%0d data_rdata", n), bus.data_rdata, vq[n].drd);
    end

    // Sustained conflict straight after reset: fixed priority keeps data,
    // round-robin alternates starting with data.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #4;
`ifdef MEM_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      check($sformatf("conflict c%0d {dgt,igt}", k), {30'd0, bus.data_gnt, bus.inst_gnt}, {30'd0, exp_g});
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    check("release {dgt,igt}", {30'd0, bus.data_gnt, bus.inst_gnt}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    #4;
    check("release inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    check("release inst_rdata", bus.inst_rdata, 32'h5A00_0041);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one synchronous single-port word memory between the rv32i instruction-fetch port and load/store port. Each requester uses a request/grant handshake. The arbiter grants at most one access per cycle, drives the memory port, and steers the one-cycle-latency read data back to the requester that was granted. It sits between the core and the 128 KiB program/data RAM.

## Interface
- `ADDR_W`, 32: requester byte-address width
- `MEM_AW`, 15: memory word-address width (32768 words = 128 KiB)
- `clk`  in  1: clock, all state on rising edge
- `reset`  in  1: synchronous, active-high
- `inst_req`  in  1: fetch request
- `inst_addr`  in  ADDR_W: fetch byte address
- `inst_gnt`  out  1: fetch accepted this cycle
- `inst_rvalid`  out  1: fetch data valid
- `inst_rdata`  out  32: fetch data
- `data_req`  in  1: load/store request
- `data_addr`  in  ADDR_W: load/store byte address
- `data_wdata`  in  32: store data
- `data_we`  in  4: byte write enables; 0 = load
- `data_gnt`  out  1: load/store accepted this cycle
- `data_rvalid`  out  1: load data valid, or store acknowledged
- `data_rdata`  out  32: load data
- `mem_en`  out  1: memory access this cycle
- `mem_addr`  out  MEM_AW: word address
- `mem_wdata`  out  32: write data
- `mem_we`  out  4: byte write enables
- `mem_rdata`  in  32: read data, valid the cycle after `mem_en`

## Operation
- **Requests:** a requester holds `req` and its address/data stable until it sees `gnt` high at a rising edge.
- **Grant selection:** combinational from the current requests and state.
  - Only one requester asserts `req`: it is granted.
  - Both assert `req`: the default policy grants `data`.
- **Memory drive:**
  - `mem_en = inst_gnt | data_gnt`.
  - `mem_addr`, `mem_wdata` and `mem_we` come from the granted requester.
  - `mem_we` is 0 for inst grants.
  - `mem_addr = addr[MEM_AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo 128 KiB. Bits [1:0] are ignored.
- **Owner register:** `owner` ∈ {NONE, INST, DATA} records this cycle's grant. It is loaded every cycle and is NONE when nothing is granted.
- **Responses:** in the cycle after a grant, `<owner>_rvalid = 1` and `<owner>_rdata = mem_rdata`.
  - The non-owner's `rvalid` is 0.
  - `rdata` is don't-care when `rvalid` is 0.
  - Stores also produce `data_rvalid`; their rdata is don't-care.
- **Pipelining:** back-to-back grants are allowed every cycle, one outstanding access per cycle. There is no internal buffering; a requester must accept `rvalid` unconditionally.

## Timing
- Grant latency is 0 cycles (same cycle as `req`). Response latency is exactly 1 cycle after `gnt`.
- Reset values:
  - `owner` = NONE
  - `inst_rvalid` = `data_rvalid` = 0
  - round-robin pointer `last` = INST
- During reset, `inst_gnt` = `data_gnt` = `mem_en` = 0 and `mem_we` = 0.
- Reset asserted in a response cycle: that response is dropped, and no `rvalid` appears in the first cycle after `reset` deasserts.
- Simultaneous requests:
  - Exactly one grant.
  - The loser keeps `req` high and is reconsidered next cycle.
- A store followed by a load to the same word on the next cycle returns the new data; ordering is that of the memory.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority, data over inst. Continuous data requests can starve fetch, which is acceptable because the core issues at most one data access per instruction.
- `MEM_ARB_RR_EN` defined: round-robin.
  - On a conflict, grant the requester that is not `last`.
  - `last` updates on every grant.
  - A single requester is always granted regardless of `last`.

## Structure
- Shared package `rv32i_mem_pkg` holds:
  - owner enum `mem_owner_t` (NONE, INST, DATA)
  - `MEM_AW_DEFAULT = 15`
  - `MMIO_OUT_ADDR = 32'h1000_0000` for later MMIO decode
- One sub-module, `mem_arb_pick`: a two-input selector taking `req[1:0]` and `last`, producing one-hot `gnt[1:0]`. It holds the policy and the `MEM_ARB_RR_EN` switch. The owner register, memory mux and response steering stay in `mem_arbiter`.

## Test plan
- **Fetch after reset:** `inst_req` at 0x0000_0010 for 1 cycle, memory word 4 = 0x0000_0013 → `inst_gnt` same cycle, `mem_addr` = 4; next cycle `inst_rvalid` = 1, `inst_rdata` = 0x0000_0013, `data_rvalid` = 0.
- **Conflict, fixed priority:** both request for 1 cycle, data store 0x1000_0000 `we` = 4'b0001 `wdata` = 0x41 → `data_gnt` = 1, `inst_gnt` = 0, `mem_we` = 0001, `mem_addr` = 0 (wrap). Next cycle `inst_gnt` = 1 and `data_rvalid` = 1.
- **Conflict, round-robin (`MEM_ARB_RR_EN`):** both request continuously for 6 cycles → grants alternate D, I, D, I, D, I starting with data after reset.
- **Store then load:** store 0xDEAD_BEEF to 0x100, then load 0x100 in the next cycle → `data_rdata` = 0xDEAD_BEEF two cycles after the store grant.
- **Reset mid-operation:** grant a fetch, assert `reset` in the response cycle for 2 cycles → no `rvalid` during or in the first cycle after reset; the first post-reset fetch returns correct data.
- **Back-to-back fetches:** fetch 0x0, 0x4, 0x8 on consecutive cycles → `inst_rvalid` high for 3 consecutive cycles with words 0, 1, 2 in order.
